// File: rtl/pm_arb_pkg.sv
// Shared types and default parameters for the program-memory arbiter.
package pm_arb_pkg;

  localparam int unsigned PM_ADDR_W         = 16;
  localparam int unsigned PM_DATA_W         = 32;
  localparam int unsigned PM_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  function automatic req_id_t other_req(req_id_t id);
    return (id == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/pm_arb_select.sv
// Winner selection between the fetch (A) and data (B) requesters.
// PM_ARB_ROUND_ROBIN_EN adds a pointer input that breaks ties; otherwise A has fixed priority.
module pm_arb_select
  import pm_arb_pkg::*;
(
  input  logic    a_req,
  input  logic    b_req,
`ifdef PM_ARB_ROUND_ROBIN_EN
  input  req_id_t ptr,
`endif
  output req_id_t winner
);

  always_comb begin
    winner = REQ_A;
`ifdef PM_ARB_ROUND_ROBIN_EN
    if (b_req && (!a_req || (ptr == REQ_B))) winner = REQ_B;
`else
    if (b_req && !a_req) winner = REQ_B;
`endif
  end

endmodule

// File: rtl/program_mem_arbiter.sv
// Two-requester program-memory read arbiter with one outstanding read and a completion timeout.
// Optional round-robin tie-breaking is enabled by defining PM_ARB_ROUND_ROBIN_EN.
module program_mem_arbiter
  import pm_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = PM_ADDR_W,
  parameter int unsigned DATA_W         = PM_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = PM_TIMEOUT_CYCLES
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              a_req_in,
  input  logic [ADDR_W-1:0] a_addr_in,
  output logic              a_gnt_out,
  output logic              a_valid_out,
  output logic              a_err_out,
  output logic [DATA_W-1:0] a_data_out,
  input  logic              b_req_in,
  input  logic [ADDR_W-1:0] b_addr_in,
  output logic              b_gnt_out,
  output logic              b_valid_out,
  output logic              b_err_out,
  output logic [DATA_W-1:0] b_data_out,
  output logic              mem_req_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic              mem_ready_in,
  input  logic              mem_valid_in,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              busy_out
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Abort is decided on cycle grant+TIMEOUT-1 so the error pulse lands TIMEOUT cycles after the grant.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  state_t            state, state_nxt;
  req_id_t           winner, owner;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt;
  logic              any_req, grant, done_ok, done_tmo, done;

  assign any_req  = a_req_in | b_req_in;
  assign grant    = (state == ST_IDLE) && any_req && !rst_in;
  assign done_ok  = (state == ST_WAIT) && mem_valid_in;
  assign done_tmo = (state != ST_IDLE) && (cnt == TMO_LAST) && !done_ok;
  assign done     = done_ok | done_tmo;
  assign mem_addr_out = addr_q;

`ifdef PM_ARB_ROUND_ROBIN_EN
  req_id_t ptr;

  always_ff @(posedge clk_in) begin
    if (rst_in)     ptr <= REQ_A;
    else if (grant) ptr <= other_req(winner);
  end

  pm_arb_select u_select (
    .a_req  (a_req_in),
    .b_req  (b_req_in),
    .ptr    (ptr),
    .winner (winner)
  );
`else
  pm_arb_select u_select (
    .a_req  (a_req_in),
    .b_req  (b_req_in),
    .winner (winner)
  );
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (any_req) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (done_tmo)          state_nxt = ST_IDLE;
        else if (mem_ready_in) state_nxt = ST_WAIT;
      end
      ST_WAIT:  if (done) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    a_gnt_out   = 1'b0;
    b_gnt_out   = 1'b0;
    mem_req_out = 1'b0;
    busy_out    = 1'b0;
    if (grant) begin
      a_gnt_out = (winner == REQ_A);
      b_gnt_out = (winner == REQ_B);
    end
    mem_req_out = (state == ST_ISSUE);
    busy_out    = (state != ST_IDLE);
  end

  // Transaction context, timeout counter and per-requester response registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      owner       <= REQ_A;
      addr_q      <= '0;
      cnt         <= '0;
      a_valid_out <= 1'b0;
      a_err_out   <= 1'b0;
      a_data_out  <= '0;
      b_valid_out <= 1'b0;
      b_err_out   <= 1'b0;
      b_data_out  <= '0;
    end else begin
      a_valid_out <= done && (owner == REQ_A);
      b_valid_out <= done && (owner == REQ_B);
      if (grant) begin
        owner  <= winner;
        addr_q <= (winner == REQ_A) ? a_addr_in : b_addr_in;
        cnt    <= '0;
      end else if (state != ST_IDLE) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (done && (owner == REQ_A)) begin
        a_err_out  <= done_tmo;
        a_data_out <= done_ok ? mem_data_in : '0;
      end
      if (done && (owner == REQ_B)) begin
        b_err_out  <= done_tmo;
        b_data_out <= done_ok ? mem_data_in : '0;
      end
    end
  end

endmodule

// File: doc/program_mem_arbiter.md
PROGRAM_MEM_ARBITER -- requirements
Module: program_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, is the program-memory word address width.
REQ-002 Parameter DATA_W, default 32, is the instruction/data word width.
REQ-003 Parameter TIMEOUT_CYCLES, default 64, is the maximum number of cycles from issue to completion before an abort.
REQ-004 clk_in  input  1  sole clock.
REQ-005 rst_in  input  1  synchronous, active-high reset.
REQ-006 a_req_in / a_addr_in  input  1 / ADDR_W  requester A (CPU fetch) read request and address.
REQ-007 a_gnt_out / a_valid_out / a_err_out / a_data_out  output  1 / 1 / 1 / DATA_W  requester A accept pulse, completion pulse, abort flag and read data.
REQ-008 b_req_in, b_addr_in, b_gnt_out, b_valid_out, b_err_out, b_data_out  have the same widths and meanings for requester B (memory-system data read).
REQ-009 mem_req_out / mem_addr_out  output  1 / ADDR_W  read request and address to program memory.
REQ-010 mem_ready_in / mem_valid_in / mem_data_in  input  1 / 1 / DATA_W  memory accepts request; memory read data is valid; read data.
REQ-011 busy_out  output  1  high whenever the FSM is not IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, ISSUE and WAIT, with exactly one transaction outstanding.
REQ-013 IDLE: if any req_in is high, select a winner, latch its address and id, pulse its gnt_out for one cycle, and go to ISSUE; otherwise stay in IDLE.
REQ-014 ISSUE: hold mem_req_out=1 and mem_addr_out=latched address; on mem_ready_in=1, go to WAIT the next cycle.
REQ-015 WAIT: on mem_valid_in=1, register mem_data_in into the winner's data_out, pulse the winner's valid_out for one cycle with err_out=0, and go to IDLE.
REQ-016 A requester SHALL be free to drop its req or change its address after its gnt_out pulse, since the address is already latched.
REQ-017 Minimum latency SHALL be: gnt at cycle T, mem_req_out at T+1 (mem_ready_in=1), mem_valid_in at T+2, valid_out at T+3, and the next grant at T+3 at the earliest.
REQ-018 Timeout: a counter SHALL clear on grant and increment in ISSUE and WAIT; when it reaches TIMEOUT_CYCLES, the block pulses the winner's valid_out with err_out=1 and data_out=0, drops mem_req_out, and returns to IDLE.
REQ-019 mem_valid_in SHALL be ignored in IDLE and ISSUE, so stale or early responses are discarded.
REQ-020 mem_valid_in and timeout arriving on the same cycle SHALL be treated as success.
REQ-021 err_out SHALL hold its value until that requester's next valid_out; data_out SHALL hold until that requester's next valid_out.
REQ-022 The non-winner's outputs SHALL be unaffected by the transaction.

Reset
REQ-023 On rst_in=1 the block SHALL enter IDLE, clear the timeout counter, set the round-robin pointer to A, and drive every output to 0; any in-flight transaction is discarded with no valid_out.
REQ-024 rst_in asserted mid-ISSUE SHALL drop mem_req_out on the following cycle.

Configuration
REQ-025 With PM_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL go to the requester indicated by the pointer, and the pointer SHALL move to the other requester after each grant.
REQ-026 With PM_ARB_ROUND_ROBIN_EN undefined, A SHALL always win over B, and no pointer SHALL exist.

Structure
REQ-027 Package pm_arb_pkg SHALL hold the FSM state enum, the requester-id typedef (REQ_A, REQ_B) and default parameter constants.
REQ-028 Winner selection SHALL live in one sub-module, pm_arb_select: inputs are both req_in signals and the pointer; output is the winner id. All sequencing stays in program_mem_arbiter.

Verification
REQ-029 a_req_in=1 with a_addr_in=0x0010, mem_ready_in tied 1, mem_valid_in 1 cycle later with data 0xDEADBEEF -> a_gnt_out at T, a_valid_out at T+3, a_data_out=0xDEADBEEF, a_err_out=0.
REQ-030 A and B both requesting continuously -> with the macro, grants alternate A,B,A,B; without it, A is granted every transaction and B never.
REQ-031 mem_ready_in held 0 for 10 cycles -> mem_req_out and mem_addr_out stay stable, busy_out=1, and completion follows normally.
REQ-032 TIMEOUT_CYCLES=8 and mem_valid_in never asserted -> b_valid_out=1, b_err_out=1, b_data_out=0 eight cycles after grant; a later mem_valid_in in IDLE produces no valid_out.
REQ-033 rst_in pulsed during WAIT -> all outputs 0 the next cycle, no valid_out for the aborted read, and the next simultaneous request is granted to A.
